// File: rtl/bus_mem_responder_pkg.sv
// Shared types and constants for the memory-bus responder.
// Bus widths, FSM encoding and the read-strobe helper.
package bus_mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int ADDR_W = 32;

  localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_write(input logic [STRB_W-1:0] strb);
    return strb != WSTRB_READ;
  endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Valid/ready memory bus between the core's arbiter (master) and main memory (slave).
interface bus_mem_responder_if;
  import bus_mem_responder_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_rdata;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;

  modport master (
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport slave (
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/bus_mem_responder_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// Read returns the pre-write contents when a write hits the same word.
module bus_mem_array
  import bus_mem_responder_pkg::*;
#(
  parameter  int WORDS = 1024,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Responder end of the core memory bus: word reads, byte-strobed writes,
// programmable wait states and an error pulse for out-of-range accesses.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                MEM_WORDS   = 1024,
  parameter int                WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  bus_mem_responder_if.slave bus,
  output logic               err
);

  // state | meaning
  // IDLE  | no request in flight; accepts s_valid unless s_ready is still high
  // WAIT  | request latched, wait counter running down to terminal count
  // RESP  | array access completed; s_ready/err/s_rdata register on exit

  localparam int              IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] SPAN      = 33'(MEM_WORDS * 4);
  localparam logic [7:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;
  localparam bit              NO_WAIT   = (WAIT_STATES == 0);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              in_range_q;

  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W:0]   offset;
  logic              in_range_now;
  logic [IDX_W-1:0]  idx_now;
  logic              accept;

  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              req_in_range;
  logic              enter_resp;

  logic              arr_en;
  logic [DATA_W-1:0] arr_rdata;

  // 33-bit offset so addresses below BASE_ADDR or near the top of the map never wrap into range
  assign word_addr    = bus.s_addr & 32'hFFFF_FFFC;
  assign offset       = {1'b0, word_addr} - {1'b0, BASE_ADDR};
  assign in_range_now = (word_addr >= BASE_ADDR) && (offset < SPAN);
  assign idx_now      = offset[IDX_W+1:2];

  // s_ready still high means the master has not yet seen completion of the previous access
  assign accept = (state == IDLE) && bus.s_valid && !bus.s_ready;

  // The zero-wait path reaches RESP straight from IDLE, so the array sees the live request
  always_comb begin
    req_idx      = idx_q;
    req_wdata    = wdata_q;
    req_wstrb    = wstrb_q;
    req_in_range = in_range_q;
    enter_resp   = 1'b0;
    if (state == IDLE) begin
      req_idx      = idx_now;
      req_wdata    = bus.s_wdata;
      req_wstrb    = bus.s_wstrb;
      req_in_range = in_range_now;
      enter_resp   = accept && NO_WAIT;
    end else if (state == WAIT) begin
      enter_resp = bus.s_valid && (wait_cnt == 8'd0);
    end
  end

  assign arr_en = enter_resp && req_in_range && !reset;

  bus_mem_array #(
    .WORDS (MEM_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (req_wstrb),
    .addr  (req_idx),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wstrb_q     <= WSTRB_READ;
      in_range_q  <= 1'b0;
      bus.s_ready <= 1'b0;
      bus.s_rdata <= '0;
      err         <= 1'b0;
    end else begin
      bus.s_ready <= 1'b0;
      bus.s_rdata <= '0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q      <= idx_now;
            wdata_q    <= bus.s_wdata;
            wstrb_q    <= bus.s_wstrb;
            in_range_q <= in_range_now;
            wait_cnt   <= WAIT_LOAD;
            state      <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!bus.s_valid) begin
            state <= IDLE;
          end else if (wait_cnt == 8'd0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        RESP: begin
          bus.s_ready <= 1'b1;
          err         <= !in_range_q;
          bus.s_rdata <= (in_range_q && !is_write(wstrb_q)) ? arr_rdata : '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Responder (slave) end of the core's 32-bit valid/ready memory bus: the port that the instruction/data arbiter's shared output drives.
- Serves single word-wide reads and byte-strobed writes from an internal word array.
- Programmable wait states model slow memory.
- Out-of-range accesses complete without hanging the bus and are flagged on a status output.
- Sits directly under the core top as the simulation/FPGA main memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- MEM_WORDS, 1024, number of 32-bit words; power of two, 2..65536.
- WAIT_STATES, 0, extra cycles between request accept and ready; 0..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  request present; master holds it until s_ready.
- s_ready  out  1  one-cycle completion pulse.
- s_addr  in  32  byte address; bits [1:0] ignored.
- s_rdata  out  32  read data; valid only while s_ready=1.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables; 4'b0000 = read, nonzero = write.
- err  out  1  one-cycle pulse, coincident with s_ready, for an out-of-range access.

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE; s_ready=0, s_rdata=0, err=0, wait counter=0. Array contents are not cleared. Reset mid-transaction aborts it, and any pending write is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If s_valid=1, latch addr/wdata/wstrb and compute in_range.
  - If WAIT_STATES=0, go to RESP; otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If counter==0, go to RESP; otherwise decrement.
  - If s_valid drops (protocol violation), return to IDLE with no write committed and no ready.
- RESP (one cycle, registered outputs): s_ready=1, err=!in_range, then return to IDLE.
  - Read, in range: s_rdata=mem[idx].
  - Read, out of range: s_rdata=0.
  - Write, in range: on the edge that enters RESP, each byte b with wstrb[b]=1 takes wdata[8b+7:8b]; unstrobed bytes are unchanged. s_rdata=0.
  - Write, out of range: discarded.
- Latency: request first seen at edge T gives s_ready high during cycle T+1+WAIT_STATES.
- Back-to-back: s_valid is ignored in RESP, and the next request is accepted in IDLE at the earliest one cycle after the s_ready cycle. Throughput is therefore one access per 3+WAIT_STATES cycles. A master that re-asserts valid immediately after ready is simply accepted one cycle later.
- in_range = (addr >= BASE_ADDR) && (addr - BASE_ADDR < 4*MEM_WORDS), computed as a 33-bit compare so there is no wrap at 32'hFFFF_FFFC.
- idx = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits; only used when in_range.
- Inputs other than s_valid are sampled only at accept. Changes to them while waiting are ignored.
- Read data reflects all writes completed before the read was accepted (no stale data).
- s_ready and err are never high outside RESP.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Bus width constants: data 32, strobe 4, address 32.
  - Strobe helper constant WSTRB_READ=4'b0000.
- Sub-module bus_mem_array: synchronous single-port word array with per-byte write enables and a registered read port. It keeps the storage inferable as block RAM; the FSM, range check and wait counter stay in the top.

Test Plan:
- WAIT_STATES=0, reset, then write addr 32'h10, wdata 32'hDEADBEEF, wstrb 4'hF, followed by a read of 32'h10 -> s_ready high exactly 2 cycles after valid for each; read returns 32'hDEADBEEF, err=0.
- Byte strobes: write 32'h11223344 (strobe F) to 32'h20, then write 32'hAABBCCDD with wstrb 4'b0101, then read 32'h20 -> 32'h11BB33DD.
- WAIT_STATES=3: read of 32'h10 -> ready exactly 5 cycles after valid rises. Back-to-back reads with valid re-asserted immediately -> one ready per 6 cycles.
- Out of range, MEM_WORDS=1024, BASE=0:
  - Write to 32'h1000 -> s_ready with err=1, no array change (read of 32'h0 unchanged).
  - Read of 32'hFFFF_FFFC -> rdata=0, err=1, no hang.
- Reset asserted during WAIT of a write to 32'h30 (WAIT_STATES=4) -> no ready pulse; after reset, read of 32'h30 returns its prior value; outputs are 0 during reset.
- Abort: s_valid dropped mid-WAIT on a write -> no ready, no write; a following valid read is served normally.
